cross_mul_arbiter: RTL and testbench
====================================

# cross_mul_arbiter

Shared cross-product engine with a round-robin arbiter for the geofence datapath. It owns one signed difference-product multiplier, (a−b)*(c−d), and shares it between up to NREQ requesters. Each requester is a point-ordering or inside-test sequencer. On grant, the block latches the three points P0, P1 and P2 of the winning requester. It then computes (x1−x0)*(y2−y0) − (y1−y0)*(x2−x0) over two multiplier passes. The signed result is returned to that requester tagged with its index.

## Interface
- NREQ, 4, number of requesters (2..8).
- CW, 10, unsigned coordinate width. The internal signed operand width is CW+1.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  request bits, one per requester.
- x0, y0, x1, y1, x2, y2  input  NREQ*CW each  packed coordinates; requester i occupies bits [i*CW +: CW].
- gnt  output  NREQ  one-hot grant, high for exactly one cycle.
- done  output  1  result-valid pulse, one cycle.
- done_id  output  3  index of the requester owning the result.
- result  output  2*CW+2  signed cross product.
- result_neg  output  1  result < 0.
- result_zero  output  1  result == 0 (collinear points).

## Operation
- FSM states: IDLE, MUL1, MUL2, DONE. Reset state is IDLE.
- **IDLE:**
  - With req == 0, remain in IDLE.
  - Otherwise the winner is the first set req bit searching upward from (last+1) mod NREQ.
  - Latch the winner's six coordinates, zero-extended to CW+1 signed.
  - Set gnt <= onehot(winner), last <= winner, id <= winner, then go to MUL1.
- **MUL1:**
  - Drive the multiplier with (x1−x0)*(y2−y0).
  - Register the product into p1 (signed 2*CW+1).
  - Clear gnt. Go to MUL2.
- **MUL2:**
  - Drive the multiplier with (y1−y0)*(x2−x0).
  - Set result <= sign-extended p1 − product, result_neg, result_zero, done <= 1, done_id <= id.
  - Go to DONE.
- **DONE:**
  - Set done <= 0. Go to IDLE.
  - result, result_neg, result_zero and done_id hold until the next MUL2.
- Exactly one multiplier instance exists. Both passes use it.
- Arithmetic and widths:
  - Each difference is CW+1 bits signed.
  - The product fits 2*CW+1 bits signed, since |product| ≤ (2^CW−1)^2.
  - The final subtraction is 2*CW+2 bits signed.
  - No saturation or overflow is possible.
- Requester rules:
  - A requester holds req and its operands stable until it samples its gnt bit high.
  - It deasserts req in the cycle after gnt unless it wants another operation.
  - A req still high when the FSM returns to IDLE is treated as a new request.
  - Dropping req before grant is legal. No grant is issued for that request.
  - Operands are sampled only on the granting edge. Later changes have no effect on the in-flight operation.
- The round-robin pointer `last` resets to NREQ−1, so requester 0 wins first.
- Requests arriving in MUL1, MUL2 or DONE wait. Nothing is dropped while req is held.

## Timing
- Reset values: gnt=0, done=0, done_id=0, result=0, result_neg=0, result_zero=1, last=NREQ−1, state IDLE.
- Edge e0: IDLE samples req != 0. gnt is high during the cycle after e0.
- Edge e2, two edges after e0: done goes high together with valid result, result_neg, result_zero and done_id.
- Edge e3: done falls. The next arbitration happens at e4.
- Throughput is one operation per 4 cycles.
- Latency from the request-sampling edge to done is 2 cycles.
- Under continuous requests from all requesters, grants rotate 0,1,2,…,NREQ−1,0. Grant-to-grant spacing is 4 cycles.
- gnt and done are never high in the same cycle.
- Reset asserted mid-operation:
  - All outputs and the FSM return to reset values immediately.
  - The in-flight result is discarded. No done is issued for it.
  - The requester keeps req high and is re-arbitrated after reset is released.

## Test plan
- Single request: req=0001 with P0=(0,0), P1=(10,0), P2=(0,10) -> gnt=0001 one cycle; 2 cycles later done=1, done_id=0, result=+100, result_neg=0.
- Orientation swap: requester 2, P1=(0,10), P2=(10,0) -> done_id=2, result=−100, result_neg=1.
- Width extremes: P0=(1023,1023), P1=(0,1023), P2=(1023,0) -> result=+1046529. Repeat with P1 and P2 swapped -> −1046529.
- Collinear: P0=(5,5), P1=(10,10), P2=(20,20) -> result=0, result_zero=1.
- Fairness: req=1111 held for 20 cycles, each requester dropping req the cycle after its gnt and re-raising it 1 cycle later -> grant order 0,1,2,3,0, each 4 cycles apart; every done_id matches the preceding grant.
- Reset mid-operation: assert reset during MUL2 with req=0010 held -> no done; outputs reset immediately; after release gnt=0010 at the first IDLE edge, then a correct result.

Source files
------------

// File: rtl/cross_mul_arbiter.sv
// cross_mul_arbiter: round-robin shared cross-product engine.
// Grants one of NREQ requesters and latches its three points P0, P1, P2.
// It then evaluates (x1-x0)*(y2-y0) - (y1-y0)*(x2-x0) over two passes of a
// single signed difference-product multiplier.
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   req[NREQ]            request bits, one per requester
//   x0..y2[NREQ*CW]      packed unsigned coordinates, requester i at [i*CW +: CW]
//   gnt[NREQ]            one-cycle one-hot grant
//   done                 one-cycle result-valid pulse
//   done_id[3]           requester index owning the result
//   result[2*CW+2]       signed cross product
//   result_neg           result < 0
//   result_zero          result == 0 (collinear points)
module cross_mul_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CW-1:0]       x0,
    input  logic [NREQ*CW-1:0]       y0,
    input  logic [NREQ*CW-1:0]       x1,
    input  logic [NREQ*CW-1:0]       y1,
    input  logic [NREQ*CW-1:0]       x2,
    input  logic [NREQ*CW-1:0]       y2,
    output logic [NREQ-1:0]          gnt,
    output logic                     done,
    output logic [2:0]               done_id,
    output logic signed [2*CW+1:0]   result,
    output logic                     result_neg,
    output logic                     result_zero
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW  = CW + 1;      // signed difference width
    localparam int unsigned PW  = 2 * CW + 1;  // signed product width
    localparam int unsigned RW  = 2 * CW + 2;  // signed result width

    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

    state_t                 state, state_nxt;
    logic [IDW-1:0]         last, id, winner;
    logic                   win_vld;
    logic [CW-1:0]          sx0, sy0, sx1, sy1, sx2, sy2;
    logic signed [DW-1:0]   cx0, cy0, cx1, cy1, cx2, cy2;
    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [PW-1:0]   prod, p1;
    logic signed [RW-1:0]   diff;

    // Round-robin search: first set req bit upward from last+1 (mod NREQ)
    always_comb begin
        logic [IDW-1:0] idx;
        idx     = '0;
        win_vld = 1'b0;
        winner  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last) + k) % NREQ);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                winner  = idx;
            end
        end
    end

    // Operand select for the winning requester
    always_comb begin
        sx0 = '0; sy0 = '0; sx1 = '0; sy1 = '0; sx2 = '0; sy2 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sx0 = x0[i*CW +: CW];
                sy0 = y0[i*CW +: CW];
                sx1 = x1[i*CW +: CW];
                sy1 = y1[i*CW +: CW];
                sx2 = x2[i*CW +: CW];
                sy2 = y2[i*CW +: CW];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplier operand steering: first pass in MUL1, second in MUL2
    always_comb begin
        mul_a = cx1 - cx0;
        mul_b = cy2 - cy0;
        if (state == MUL2) begin
            mul_a = cy1 - cy0;
            mul_b = cx2 - cx0;
        end
    end

    // The single shared multiplier; |product| <= (2^CW-1)^2 fits PW signed
    assign prod = PW'(mul_a) * PW'(mul_b);
    assign diff = RW'(p1) - RW'(prod);

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt         <= '0;
            done        <= 1'b0;
            done_id     <= '0;
            result      <= '0;
            result_neg  <= 1'b0;
            result_zero <= 1'b1;
            last        <= IDW'(NREQ - 1);
            id          <= '0;
            p1          <= '0;
            cx0 <= '0; cy0 <= '0; cx1 <= '0; cy1 <= '0; cx2 <= '0; cy2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        cx0  <= {1'b0, sx0};
                        cy0  <= {1'b0, sy0};
                        cx1  <= {1'b0, sx1};
                        cy1  <= {1'b0, sy1};
                        cx2  <= {1'b0, sx2};
                        cy2  <= {1'b0, sy2};
                        gnt  <= NREQ'(1) << winner;
                        last <= winner;
                        id   <= winner;
                    end
                end
                MUL1: begin
                    p1  <= prod;
                    gnt <= '0;
                end
                MUL2: begin
                    result      <= diff;
                    result_neg  <= diff[RW-1];
                    result_zero <= (diff == '0);
                    done        <= 1'b1;
                    done_id     <= 3'(id);
                end
                DONE: done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cross_mul_arbiter.sv
// tb_cross_mul_arbiter: directed bench for cross_mul_arbiter with
// hand-computed expected cross products.
module tb_cross_mul_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 10;
    localparam int unsigned RW   = 2 * CW + 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*CW-1:0]     x0, y0, x1, y1, x2, y2;
    logic [NREQ-1:0]        gnt;
    logic                   done;
    logic [2:0]             done_id;
    logic signed [RW-1:0]   result;
    logic                   result_neg;
    logic                   result_zero;

    int vectors     = 0;
    int miscompares = 0;

    cross_mul_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .gnt(gnt), .done(done), .done_id(done_id), .result(result),
        .result_neg(result_neg), .result_zero(result_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic signed [RW-1:0] obs, input int exp);
        vectors++;
        assert (obs === RW'(exp)) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pts(input int i, input int ax0, input int ay0, input int ax1,
                           input int ay1, input int ax2, input int ay2);
        x0[i*CW +: CW] = CW'(ax0);
        y0[i*CW +: CW] = CW'(ay0);
        x1[i*CW +: CW] = CW'(ax1);
        y1[i*CW +: CW] = CW'(ay1);
        x2[i*CW +: CW] = CW'(ax2);
        y2[i*CW +: CW] = CW'(ay2);
    endtask

    // One complete single-requester operation starting from IDLE
    task automatic run_op(input string name, input int i, input int exp_res);
        logic [NREQ-1:0] oh;
        oh  = NREQ'(1) << i;
        req = oh;
        step();
        chk({name, ".gnt"}, 32'(gnt), 32'(oh));
        chk({name, ".done_at_gnt"}, 32'(done), 32'(0));
        req = '0;
        step();
        chk({name, ".gnt_clear"}, 32'(gnt), 32'(0));
        chk({name, ".done_early"}, 32'(done), 32'(0));
        step();
        chk({name, ".done"}, 32'(done), 32'(1));
        chk({name, ".done_id"}, 32'(done_id), 32'(i));
        chk_res({name, ".result"}, result, exp_res);
        chk({name, ".neg"}, 32'(result_neg), 32'(exp_res < 0));
        chk({name, ".zero"}, 32'(result_zero), 32'(exp_res == 0));
        step();
        chk({name, ".done_fall"}, 32'(done), 32'(0));
        chk_res({name, ".result_hold"}, result, exp_res);
    endtask

    initial begin
        logic [NREQ-1:0] eg;
        reset = 1'b1;
        req   = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        step();
        step();
        chk("rst.gnt", 32'(gnt), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.done_id", 32'(done_id), 32'(0));
        chk_res("rst.result", result, 0);
        chk("rst.neg", 32'(result_neg), 32'(0));
        chk("rst.zero", 32'(result_zero), 32'(1));
        reset = 1'b0;

        // Fairness: all four request, each drops for one cycle after its grant
        for (int i = 0; i < int'(NREQ); i++) set_pts(i, 0, 0, i + 1, 0, 0, 1);
        req = '1;
        for (int k = 0; k < 20; k++) begin
            step();
            eg = (k % 4 == 0) ? NREQ'(1) << ((k / 4) % 4) : '0;
            chk($sformatf("rr.gnt[%0d]", k), 32'(gnt), 32'(eg));
            chk($sformatf("rr.done[%0d]", k), 32'(done), 32'(k % 4 == 2));
            if (k % 4 == 2) begin
                chk($sformatf("rr.done_id[%0d]", k), 32'(done_id), 32'((k / 4) % 4));
                chk_res($sformatf("rr.result[%0d]", k), result, (k / 4) % 4 + 1);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!req[i]) req[i] = 1'b1;
                if (gnt[i])  req[i] = 1'b0;
            end
        end
        req = '0;
        step();

        set_pts(0, 0, 0, 10, 0, 0, 10);
        run_op("single", 0, 100);

        set_pts(2, 0, 0, 0, 10, 10, 0);
        run_op("swap", 2, -100);

        set_pts(3, 1023, 1023, 0, 1023, 1023, 0);
        run_op("wmax_pos", 3, 1046529);

        set_pts(1, 1023, 1023, 1023, 0, 0, 1023);
        run_op("wmax_neg", 1, -1046529);

        // Reset during MUL2 with req held: result discarded, re-arbitrated
        set_pts(1, 0, 0, 10, 0, 0, 10);
        req = 4'b0010;
        step();
        chk("mrst.gnt", 32'(gnt), 32'(4'b0010));
        step();
        reset = 1'b1;
        #1;
        chk("mrst.gnt_rst", 32'(gnt), 32'(0));
        chk("mrst.done_rst", 32'(done), 32'(0));
        chk("mrst.done_id_rst", 32'(done_id), 32'(0));
        chk_res("mrst.result_rst", result, 0);
        chk("mrst.neg_rst", 32'(result_neg), 32'(0));
        chk("mrst.zero_rst", 32'(result_zero), 32'(1));
        step();
        chk("mrst.no_done", 32'(done), 32'(0));
        reset = 1'b0;
        step();
        chk("mrst.regnt", 32'(gnt), 32'(4'b0010));
        req = '0;
        step();
        chk("mrst.no_done2", 32'(done), 32'(0));
        step();
        chk("mrst.done", 32'(done), 32'(1));
        chk("mrst.done_id", 32'(done_id), 32'(1));
        chk_res("mrst.result", result, 100);
        step();
        chk("mrst.done_fall", 32'(done), 32'(0));

        set_pts(0, 5, 5, 10, 10, 20, 20);
        run_op("collinear", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
